// File: rtl/univ_shift_register.sv
// Universal shift register stepped by a free-running prescaler tick.
// Eight operations are selected by mode; step and steps report each performed step.
module univ_shift_register #(
    parameter int WIDTH = 4,
    parameter int DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             step,
    output logic [15:0]      steps
);

    // A one-bit counter is kept for DIV = 1; it simply stays at zero.
    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             tick_s;
    logic             do_step_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             step_r;
    logic [15:0]      steps_r;

    // Prescaler next count and step qualification
    always_comb begin
        tick_s      = (count_r == CNT_LAST);
        do_step_s   = tick_s & en;
        count_nxt_s = count_r;
        if (tick_s) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r + CNT_W'(1);
        end
    end

    // Operation decode: the value q takes if this edge performs a step
    always_comb begin
        q_nxt_s = q_r;
        case (mode)
            3'b000:  q_nxt_s = q_r;
            3'b001:  q_nxt_s = {sin, q_r[WIDTH-1:1]};
            3'b010:  q_nxt_s = {q_r[WIDTH-2:0], sin};
            3'b011:  q_nxt_s = {q_r[0], q_r[WIDTH-1:1]};
            3'b100:  q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            3'b101:  q_nxt_s = pdata;
            3'b110:  q_nxt_s = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            3'b111:  q_nxt_s = '0;
            default: q_nxt_s = q_r;
        endcase
    end

    // State registers; reset wins over any pending tick
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            q_r     <= '0;
            step_r  <= 1'b0;
            steps_r <= 16'h0000;
        end else begin
            count_r <= count_nxt_s;
            step_r  <= do_step_s;
            if (do_step_s) begin
                q_r     <= q_nxt_s;
                steps_r <= steps_r + 16'h0001;
            end else begin
                q_r     <= q_r;
                steps_r <= steps_r;
            end
        end
    end

    assign q     = q_r;
    assign step  = step_r;
    assign steps = steps_r;

endmodule

// File: tb/tb_univ_shift_register.sv
// Bench for univ_shift_register: DIV=1 and DIV=3 instances share stimulus and are
// compared every cycle against an arithmetic reference model, plus directed scenarios.
module tb_univ_shift_register;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  mode;
    logic        sin;
    logic [3:0]  pdata;
    logic [3:0]  q1;
    logic        step1;
    logic [15:0] steps1;
    logic [3:0]  q3;
    logic        step3;
    logic [15:0] steps3;

    int n_checks = 0;
    int n_errors = 0;

    int m_q[2];
    int m_step[2];
    int m_steps[2];
    int m_cyc[2];
    int div_c[2] = '{1, 3};
    int sr_bits[4] = '{1, 0, 1, 1};

    univ_shift_register #(.WIDTH(4), .DIV(1)) u_dut_d1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin),
        .pdata(pdata), .q(q1), .step(step1), .steps(steps1)
    );

    univ_shift_register #(.WIDTH(4), .DIV(3)) u_dut_d3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin),
        .pdata(pdata), .q(q3), .step(step3), .steps(steps3)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Register contents after one operation, treating q as a 4-bit unsigned number.
    function automatic int ref_op(input int qv, input int md, input int s, input int pd);
        case (md)
            1:       return (qv / 2) + s * 8;
            2:       return (qv * 2 + s) % 16;
            3:       return (qv / 2) + (qv % 2) * 8;
            4:       return (qv * 2) % 16 + (qv / 8);
            5:       return pd;
            6:       return (qv / 2) + ((qv >= 8) ? 8 : 0);
            7:       return 0;
            default: return qv;
        endcase
    endfunction

    // Advance the model with the currently driven inputs, clock once, compare both DUTs.
    task automatic clk_cycle();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_q[k] = 0; m_step[k] = 0; m_steps[k] = 0; m_cyc[k] = 0;
            end else begin
                m_step[k] = ((m_cyc[k] % div_c[k]) == div_c[k] - 1 && en) ? 1 : 0;
                m_cyc[k]++;
                if (m_step[k] == 1) begin
                    m_q[k]     = ref_op(m_q[k], int'(mode), int'(sin), int'(pdata));
                    m_steps[k] = (m_steps[k] + 1) % 65536;
                end
            end
        end
        @(posedge clk);
        #1;
        chk_eq("d1.q",     int'(q1),     m_q[0]);
        chk_eq("d1.step",  int'(step1),  m_step[0]);
        chk_eq("d1.steps", int'(steps1), m_steps[0]);
        chk_eq("d3.q",     int'(q3),     m_q[1]);
        chk_eq("d3.step",  int'(step3),  m_step[1]);
        chk_eq("d3.steps", int'(steps3), m_steps[1]);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; en = 1'b0; mode = 3'b000; sin = 1'b0; pdata = 4'h0;
        clk_cycle();
        chk_eq("rst.q1", int'(q1), 0);
        chk_eq("rst.step3", int'(step3), 0);
        chk_eq("rst.steps3", int'(steps3), 0);
        reset = 1'b0;

        // Serial shift right on DIV=1
        en = 1'b1; mode = 3'b001;
        for (int i = 0; i < 4; i++) begin
            sin = 1'(sr_bits[i]);
            clk_cycle();
            chk_eq("sr.step", int'(step1), 1);
        end
        chk_eq("sr.q", int'(q1), 13);
        chk_eq("sr.steps", int'(steps1), 4);

        // Arithmetic shift right and rotate right on DIV=1
        mode = 3'b101; pdata = 4'b1000; clk_cycle();
        mode = 3'b110; clk_cycle(); chk_eq("asr1.q", int'(q1), 12);
        clk_cycle();                chk_eq("asr2.q", int'(q1), 14);
        mode = 3'b011; clk_cycle(); chk_eq("ror.q", int'(q1), 7);

        // Load then rotate left on DIV=3, ticks every third clk
        reset = 1'b1; clk_cycle(); reset = 1'b0;
        mode = 3'b101; pdata = 4'b1001;
        clk_cycle(); chk_eq("ld.nostep1", int'(step3), 0);
        clk_cycle(); chk_eq("ld.nostep2", int'(step3), 0);
        clk_cycle(); chk_eq("ld.step", int'(step3), 1);
        chk_eq("ld.q", int'(q3), 9);
        mode = 3'b100;
        repeat (3) clk_cycle();
        chk_eq("rol.q", int'(q3), 3);

        // en low across two ticks loses them; next enabled tick clears
        en = 1'b0; mode = 3'b111;
        repeat (6) clk_cycle();
        chk_eq("gate.q", int'(q3), 3);
        chk_eq("gate.steps", int'(steps3), 2);
        en = 1'b1;
        repeat (3) clk_cycle();
        chk_eq("clr.q", int'(q3), 0);
        chk_eq("clr.steps", int'(steps3), 3);

        // Reset one clk before a tick with q=1111
        mode = 3'b101; pdata = 4'hF;
        repeat (3) clk_cycle();
        chk_eq("pre.q", int'(q3), 15);
        mode = 3'b000;
        for (int i = 0; i < 3 && (m_cyc[1] % 3) != 1; i++) clk_cycle();
        reset = 1'b1; clk_cycle(); reset = 1'b0;
        chk_eq("mid.q", int'(q3), 0);
        chk_eq("mid.steps", int'(steps3), 0);
        chk_eq("mid.step", int'(step3), 0);
        clk_cycle(); chk_eq("post.step1", int'(step3), 0);
        clk_cycle(); chk_eq("post.step2", int'(step3), 0);
        clk_cycle(); chk_eq("post.step3", int'(step3), 1);

        // steps wraps 0xFFFF -> 0x0000 on DIV=1 with q held
        reset = 1'b1; clk_cycle(); reset = 1'b0;
        mode = 3'b101; pdata = 4'h5; clk_cycle();
        mode = 3'b000;
        repeat (65534) clk_cycle();
        chk_eq("wrap.pre", int'(steps1), 65535);
        clk_cycle();
        chk_eq("wrap.steps", int'(steps1), 0);
        chk_eq("wrap.q", int'(q1), 5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(63) == 0);
            en    = ($urandom_range(3) != 0);
            mode  = 3'($urandom_range(7));
            sin   = 1'($urandom_range(1));
            pdata = 4'($urandom_range(15));
            clk_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_register.md
UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

Interface
REQ-001 SHALL have parameter: WIDTH, 4, register length in bits (legal range 2..32).
REQ-002 SHALL have parameter: DIV, 25000000, prescaler period in clk cycles per step tick (legal range 1..2^26).
REQ-003 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: en  input  1  step enable, gates register updates on tick.
REQ-006 SHALL have port: mode  input  3  operation select, decoded per REQ-012.
REQ-007 SHALL have port: sin  input  1  serial data in.
REQ-008 SHALL have port: pdata  input  WIDTH  parallel load data.
REQ-009 SHALL have port: q  output  WIDTH  register contents, registered.
REQ-010 SHALL have port: step  output  1  one-clk pulse, high in the cycle after q was updated by a step.
REQ-011 SHALL have port: steps  output  16  count of performed steps, registered.

Function
REQ-012 SHALL decode mode as: 000 hold; 001 shift right (sin -> q[WIDTH-1], q[i] <- q[i+1]); 010 shift left (sin -> q[0], q[i] <- q[i-1]); 011 rotate right (q[0] -> q[WIDTH-1]); 100 rotate left (q[WIDTH-1] -> q[0]); 101 parallel load (q <- pdata); 110 arithmetic shift right (q[WIDTH-1] retained); 111 clear (q <- 0).
REQ-013 SHALL contain a free-running prescaler counting 0..DIV-1, wrapping to 0, with internal tick high for exactly the one clk where count == DIV-1.
REQ-014 SHALL, for DIV = 1, assert tick on every clk cycle.
REQ-015 SHALL perform a step only on a clk edge where tick = 1 and en = 1; mode, sin and pdata are sampled on that edge only.
REQ-016 SHALL leave q unchanged on every edge where tick = 0 or en = 0.
REQ-017 SHALL treat mode 000 with tick & en as a performed step (step pulses, steps increments, q unchanged).
REQ-018 SHALL register step as (tick & en) from the previous edge: step is high for exactly one clk, aligned with the new q value.
REQ-019 SHALL increment steps by 1 per performed step, wrapping 0xFFFF -> 0x0000 without flag.
REQ-020 SHALL keep the prescaler running regardless of en and mode; deasserting en loses ticks, never delays them.
REQ-021 SHALL make changes to mode, sin, pdata between ticks have no effect on q.

Reset
REQ-022 SHALL, on any clk edge with reset = 1, set q = 0, steps = 0, step = 0, prescaler count = 0; reset overrides tick, en and mode.
REQ-023 SHALL, after reset deasserts, produce the first tick exactly DIV clk cycles after the last reset edge (DIV-1 counts then tick).
REQ-024 SHALL allow reset mid-operation at any prescaler phase, abandoning any pending step, with no step pulse in the cycle following the reset edge.

Verification
REQ-025 SHALL be verified: WIDTH=4, DIV=1, en=1, mode=001, sin sequence 1,0,1,1 -> q = 1000, 0100, 1010, 1101 after successive edges; step high every cycle; steps = 4.
REQ-026 SHALL be verified: WIDTH=4, DIV=3, load pdata=1001 (mode=101) then mode=100 -> q = 1001 then 0011 on next tick, ticks exactly every 3rd clk, step pulses one clk each.
REQ-027 SHALL be verified: WIDTH=4, DIV=1, q=1000, mode=110 twice -> q = 1100 then 1110; then mode=011 -> q = 0111.
REQ-028 SHALL be verified: DIV=3, en=0 across two ticks with mode=111 -> q unchanged, step never high, steps unchanged; en=1 on next tick -> q = 0.
REQ-029 SHALL be verified: DIV=3, reset asserted one clk before a tick with q=1111 -> q = 0, steps = 0, no step pulse; next tick 3 clks after reset releases.
REQ-030 SHALL be verified: DIV=1, steps preset by 65535 hold steps -> next step gives steps = 0x0000 and q unchanged.
